// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and helpers for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Number of byte beats for an access size; the unused code 2'b11 moves a word.
    function automatic logic [2:0] beats(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and byte-RAM port of the unified memory arbiter.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_rw;
    logic [1:0]        dm_size;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ack;

    logic              ram_en;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    logic              stall_if;
    logic              stall_mem;

    // Pipeline plus RAM side.
    modport master (
        output if_req, if_addr, dm_req, dm_rw, dm_size, dm_addr, dm_wdata, ram_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  ram_en, ram_rw, ram_addr, ram_wdata, stall_if, stall_mem
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dm_req, dm_rw, dm_size, dm_addr, dm_wdata, ram_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output ram_en, ram_rw, ram_addr, ram_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/unified_mem_arbiter_byte_lane.sv
// Beat counter, MSB-first write byte selection and read shift accumulator.
module mem_byte_lane
    import mem_arb_pkg::*;
(
    input  logic        CLK,
    input  logic        CLR,
    input  logic        load,       // grant in IDLE: restart at beat 0
    input  logic        step,       // one beat completes this cycle
    input  logic [1:0]  size,       // size of the access being (or about to be) moved
    input  logic [31:0] wdata,      // right-justified write data of that access
    input  logic [7:0]  ram_rdata,
    output logic        last,       // current beat is the final one
    output logic [7:0]  wbyte_nxt,  // byte to present on the RAM for the next beat
    output logic [31:0] rdata_nxt   // accumulator including the byte read this beat
);
    logic [1:0]  beat_q, beat_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  n_beats;
    logic [1:0]  nxt_beat;
    logic [1:0]  byte_idx;

    assign n_beats   = beats(size);
    assign last      = ({1'b0, beat_q} == (n_beats - 3'd1));
    assign nxt_beat  = load ? 2'd0 : beat_q + 2'd1;
    // Beat 0 carries the most significant byte of the item.
    assign byte_idx  = 2'(n_beats - 3'd1 - {1'b0, nxt_beat});
    assign wbyte_nxt = 8'(wdata >> {byte_idx, 3'b000});
    // Clearing on load makes the shifted result zero-extended for short reads.
    assign rdata_nxt = {acc_q[23:0], ram_rdata};

    // Next beat index and accumulator contents.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        beat_d = beat_q;
        acc_d  = acc_q;
        if (load) begin
            beat_d = 2'd0;
            acc_d  = 32'd0;
        end else if (step) begin
            beat_d = last ? 2'd0 : beat_q + 2'd1;
            acc_d  = rdata_nxt;
        end
    end

    // Lane state registers.
    always_ff @(posedge CLK or negedge CLR) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!CLR) begin
            beat_q <= 2'd0;
            acc_q  <= 32'd0;
        end else begin
            beat_q <= beat_d;
            acc_q  <= acc_d;
        end
    end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one byte-wide RAM between instruction fetch and data access, round-robin.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                   CLK,
    input  logic                   CLR,
    unified_mem_arbiter_if.slave   bus
);
    state_e            state_q, state_d;
    grant_e            gnt_q, gnt_d;
    grant_e            last_grant_q, last_grant_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;

    logic              req_any;
    logic              win_dm;
    logic [1:0]        sel_size;
    logic [31:0]       sel_wdata;
    logic              lane_last;
    logic [7:0]        lane_wbyte;
    logic [31:0]       lane_rdata;

    // A lone requester wins; on a conflict the port not granted last time wins.
    assign req_any   = bus.if_req | bus.dm_req;
    assign win_dm    = bus.dm_req & (~bus.if_req | (last_grant_q == GNT_IF));
    // The lane sees the winner's request while granting and the latched copy afterwards.
    assign sel_size  = (state_q == IDLE) ? (win_dm ? bus.dm_size : SZ_WORD) : size_q;
    assign sel_wdata = (state_q == IDLE) ? (win_dm ? bus.dm_wdata : 32'd0) : wdata_q;

    mem_byte_lane u_lane (
        .CLK       (CLK),
        .CLR       (CLR),
        .load      ((state_q == IDLE) && req_any),
        .step      (state_q == XFER),
        .size      (sel_size),
        .wdata     (sel_wdata),
        .ram_rdata (bus.ram_rdata),
        .last      (lane_last),
        .wbyte_nxt (lane_wbyte),
        .rdata_nxt (lane_rdata)
    );

    // FSM next state, grant, RAM drive and completion values.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        rw_d         = rw_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        ram_en_d     = ram_en_q;
        ram_rw_d     = ram_rw_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    gnt_d        = win_dm ? GNT_DM : GNT_IF;
                    last_grant_d = gnt_d;
                    rw_d         = win_dm & bus.dm_rw;
                    size_d       = sel_size;
                    wdata_d      = sel_wdata;
                    ram_en_d     = 1'b1;
                    ram_rw_d     = rw_d;
                    ram_addr_d   = win_dm ? bus.dm_addr : bus.if_addr;
                    ram_wdata_d  = lane_wbyte;
                    state_d      = XFER;
                end
            end
            XFER: begin
                if (lane_last) begin
                    ram_en_d = 1'b0;
                    ram_rw_d = 1'b0;
                    state_d  = DONE;
                    if (gnt_q == GNT_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = lane_rdata;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!rw_q) dm_rdata_d = lane_rdata;
                    end
                end else begin
                    ram_addr_d  = ram_addr_q + ADDR_W'(1);
                    ram_wdata_d = lane_wbyte;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All state and outputs registered; reset aborts any transfer in flight.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_IF;
            last_grant_q <= GNT_IF;
            rw_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            wdata_q      <= 32'd0;
            ram_en_q     <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 8'd0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= 32'd0;
            dm_rdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            rw_q         <= rw_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            ram_en_q     <= ram_en_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_rw    = ram_rw_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_mem = bus.dm_req & ~dm_ack_q;
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares the single byte-wide 256x8 RAM between the IF-stage instruction fetch and the MEM-stage data access. Serialises each halfword or word request into byte beats, arbitrates conflicting requests round-robin, and returns assembled big-endian data. The pipeline uses the per-port `stall_*` outputs to freeze the PC/IF-ID and the EX-MEM/MEM-WB registers while its request is outstanding.

## Interface
- `ADDR_W`, default 8: RAM byte-address width; all address arithmetic is modulo 2^ADDR_W.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `CLR` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; always a word read.
- `if_addr` in ADDR_W: fetch byte address.
- `if_rdata` out 32: fetched instruction; valid while `if_ack`=1.
- `if_ack` out 1: one-cycle completion pulse for a fetch.
- `dm_req` in 1: data request.
- `dm_rw` in 1: 1 = write, 0 = read.
- `dm_size` in 2: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `dm_addr` in ADDR_W: data byte address.
- `dm_wdata` in 32: write data, right-justified.
- `dm_rdata` out 32: read data, zero-extended; valid while `dm_ack`=1.
- `dm_ack` out 1: one-cycle completion pulse for a data access.
- `ram_en` out 1: RAM enable.
- `ram_rw` out 1: RAM direction, 1 = write.
- `ram_addr` out ADDR_W: RAM byte address.
- `ram_wdata` out 8: RAM write byte.
- `ram_rdata` in 8: RAM read byte; combinational in `ram_addr`.
- `stall_if` out 1: equals `if_req & ~if_ack`.
- `stall_mem` out 1: equals `dm_req & ~dm_ack`.

## Operation
- FSM states:
  - IDLE: no requests pending → stay in IDLE. Any request pending → grant, latch the winner's addr/rw/size/wdata, set beat=0, go to XFER.
  - XFER: one byte per cycle. `ram_en`=1, `ram_addr`=latched addr+beat (wraps 255→0), `ram_rw`=latched rw. On the final beat go to DONE.
  - DONE: pulse the granted port's ack; the matching rdata is valid. Next state is IDLE unconditionally.
- Beat count N: 1 for byte, 2 for halfword, 4 for word or fetch.
- Arbitration:
  - Only one requester → that requester wins.
  - Both requesters → the port not granted last wins.
  - `last_grant` resets to IF, so the first conflict after reset goes to DM.
- Byte order is big-endian: beat 0 carries the most significant byte of the item.
  - Writes: word sends wdata[31:24] first; halfword sends [15:8] then [7:0]; byte sends [7:0].
  - Reads: each beat shifts `ram_rdata` into an accumulator. The result is zero-extended to 32 bits.
- Request and data capture:
  - Request inputs are sampled only in IDLE. Changes after the grant are ignored.
  - Deasserting a request mid-transfer does not abort it; the ack still pulses.
  - Alignment is not enforced. Misaligned accesses just read consecutive bytes with address wrap.
- Write outputs: on writes, `dm_rdata` holds its previous value and `ram_wdata` is don't-care on reads.
- Reset:
  - Reset (including reset mid-transfer) forces IDLE, beat=0, last_grant=IF.
  - All outputs go to 0: ram_en, ram_rw, ram_addr, ram_wdata, acks, and both rdata.
  - A partially written word is left partially written; this is accepted behaviour.

## Timing
- Request seen in IDLE at edge k → beats occupy cycles k+1..k+N → ack high in cycle k+N+1.
- Word latency is 5 cycles (request to ack); byte latency is 2 cycles.
- IDLE is re-entered at k+N+2, so back-to-back transactions have a 1-cycle gap. Throughput for a word is 6 cycles.
- RAM outputs (`ram_en`, `ram_addr`, etc.) are registered and change only on `CLK` edges.
- `rdata` registers update only in DONE.
- `stall_*` is combinational from the request input and the registered ack.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, XFER, DONE);
  - size codes (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10);
  - the function `beats(size)` → 1/2/4;
  - the grant encoding (GNT_IF=0, GNT_DM=1).
- One sub-module, `mem_byte_lane`, holds:
  - the beat counter;
  - write-byte selection (MSB-first for the given size);
  - the read shift accumulator with zero-extension.
- The top level holds the FSM, arbitration, and ack/rdata registers.

## Test plan
- Fetch only:
  - Stimulus: RAM[0x10..0x13]=E3,A0,10,05; `if_req`=1, `if_addr`=0x10 at cycle 0.
  - Expected: ram_addr=0x10,0x11,0x12,0x13 in cycles 1-4; `if_ack`=1 with `if_rdata`=0xE3A01005 in cycle 5; `stall_if`=1 in cycles 0-4.
- Data halfword write then byte read:
  - Stimulus: `dm_wdata`=0x0000BEEF, size 01, addr 0x20; then a byte read at 0x21.
  - Expected: RAM[0x20]=BE, RAM[0x21]=EF; the read returns `dm_rdata`=0x000000EF.
- Simultaneous requests from reset:
  - Stimulus: both ports request in the same cycle.
  - Expected: DM is granted first; IF is granted after the DM DONE.
  - Follow-up: re-request both together → DM wins again (last=IF); a third conflict → IF.
- Address wrap:
  - Stimulus: word read at 0xFE with RAM[FE,FF,00,01]=11,22,33,44.
  - Expected: ram_addr sequence FE,FF,00,01; rdata=0x11223344.
- Reset mid-write:
  - Stimulus: word write 0xAABBCCDD to 0x40; assert `CLR`=0 during beat 2.
  - Expected: all outputs are 0 immediately; RAM[0x40]=AA and RAM[0x41]=BB only; no ack; after release the FSM is in IDLE.
- Request dropped:
  - Stimulus: deassert `dm_req` in beat 1 of a word read.
  - Expected: all 4 beats still occur; `dm_ack` pulses in cycle 5 with the correct data.
